// File: rtl/fp_normalize_pack.sv
// rtl/fp_normalize_pack.sv - FP add/sub back end: one-bit-per-cycle normalize, optional RNE round, IEEE pack
// Define FP_ROUND_EN to enable the round-to-nearest-even state; otherwise the result is truncated.
module fp_normalize_pack #(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MANT_W+1:0]       mant_sum,
  input  logic [2:0]              grs,
  input  logic [EXP_W-1:0]        exp_in,
  input  logic                    sign_res,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W:0]   result,
  output logic                    flag_zero,
  output logic                    flag_ovf,
  output logic                    flag_unf
);
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  state_t state, state_n;

  logic [MANT_W+1:0]     mant_r, mant_n;
  logic                  g_r, r_r, s_r, g_n, r_n, s_n;
  logic [EXP_W-1:0]      exp_r, exp_n, exp_inc;
  logic                  sign_r, sign_n;
  logic [EXP_W+MANT_W:0] result_r, result_n, inf_word;
  logic                  zero_r, zero_n, ovf_r, ovf_n, unf_r, unf_n;
`ifdef FP_ROUND_EN
  logic                  round_up;
  logic [MANT_W+1:0]     round_sum;
`endif

  assign in_ready  = (state == IDLE) & ~rst;
  assign out_valid = (state == DONE);
  assign result    = result_r;
  assign flag_zero = zero_r;
  assign flag_ovf  = ovf_r;
  assign flag_unf  = unf_r;
  assign exp_inc   = exp_r + EXP_ONE;
  assign inf_word  = {sign_r, EXP_MAX, {MANT_W{1'b0}}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mant_r   <= '0;
      g_r      <= 1'b0;
      r_r      <= 1'b0;
      s_r      <= 1'b0;
      exp_r    <= '0;
      sign_r   <= 1'b0;
      result_r <= '0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      state    <= state_n;
      mant_r   <= mant_n;
      g_r      <= g_n;
      r_r      <= r_n;
      s_r      <= s_n;
      exp_r    <= exp_n;
      sign_r   <= sign_n;
      result_r <= result_n;
      zero_r   <= zero_n;
      ovf_r    <= ovf_n;
      unf_r    <= unf_n;
    end
  end

  always_comb begin
    state_n  = state;
    mant_n   = mant_r;
    g_n      = g_r;
    r_n      = r_r;
    s_n      = s_r;
    exp_n    = exp_r;
    sign_n   = sign_r;
    result_n = result_r;
    zero_n   = zero_r;
    ovf_n    = ovf_r;
    unf_n    = unf_r;
`ifdef FP_ROUND_EN
    round_up  = 1'b0;
    round_sum = '0;
`endif
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          mant_n              = mant_sum;
          {g_n, r_n, s_n}     = grs;
          exp_n               = (exp_in == '0) ? EXP_ONE : exp_in;
          sign_n              = sign_res;
          zero_n              = 1'b0;
          ovf_n               = 1'b0;
          unf_n               = 1'b0;
          state_n             = NORM;
        end
      end
      NORM: begin
        if (mant_r == '0 && !g_r && !r_r && !s_r) begin
          result_n = '0;
          zero_n   = 1'b1;
          unf_n    = 1'b0;
          state_n  = DONE;
        end else if (exp_r == EXP_MAX) begin
          result_n = inf_word;
          ovf_n    = 1'b1;
          state_n  = DONE;
        end else if (mant_r[MANT_W+1]) begin
          mant_n = mant_r >> 1;
          g_n    = mant_r[0];
          r_n    = g_r;
          s_n    = r_r | s_r;
          exp_n  = exp_inc;
          if (exp_inc == EXP_MAX) begin
            result_n = inf_word;
            ovf_n    = 1'b1;
            state_n  = DONE;
          end
        end else if (!mant_r[MANT_W] && exp_r > EXP_ONE) begin
          // Sticky stays put on left shifts: it only records bits already lost below R.
          mant_n = {mant_r[MANT_W:0], g_r};
          g_n    = r_r;
          r_n    = 1'b0;
          exp_n  = exp_r - EXP_ONE;
        end else begin
          if (!mant_r[MANT_W]) begin
            exp_n = '0;
            unf_n = 1'b1;
          end
`ifdef FP_ROUND_EN
          state_n = ROUND;
`else
          result_n = {sign_r, (mant_r[MANT_W] ? exp_r : {EXP_W{1'b0}}), mant_r[MANT_W-1:0]};
          state_n  = DONE;
`endif
        end
      end
`ifdef FP_ROUND_EN
      ROUND: begin
        round_up  = g_r & (r_r | s_r | mant_r[0]);
        round_sum = mant_r + {{(MANT_W+1){1'b0}}, round_up};
        mant_n    = round_sum;
        state_n   = DONE;
        if (round_sum[MANT_W+1]) begin
          mant_n = round_sum >> 1;
          exp_n  = exp_inc;
          if (exp_inc == EXP_MAX) begin
            result_n = inf_word;
            ovf_n    = 1'b1;
            unf_n    = 1'b0;
          end else begin
            result_n = {sign_r, exp_inc, round_sum[MANT_W:1]};
          end
        end else if (unf_r && round_sum[MANT_W]) begin
          // A denormal that rounds up into the hidden bit becomes the smallest normal.
          exp_n    = EXP_ONE;
          unf_n    = 1'b0;
          result_n = {sign_r, EXP_ONE, round_sum[MANT_W-1:0]};
        end else begin
          result_n = {sign_r, exp_r, round_sum[MANT_W-1:0]};
        end
      end
`endif
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_fp_normalize_pack.sv
// tb/tb_fp_normalize_pack.sv - directed bench for fp_normalize_pack with value-level reference model
module tb_fp_normalize_pack;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [24:0] mant_sum;
  logic [2:0]  grs;
  logic [7:0]  exp_in;
  logic        sign_res;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        flag_zero, flag_ovf, flag_unf;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [34:0] exp_q[$];

  always #5 clk = ~clk;

  fp_normalize_pack #(.EXP_W(8), .MANT_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .mant_sum(mant_sum), .grs(grs), .exp_in(exp_in), .sign_res(sign_res),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_zero(flag_zero), .flag_ovf(flag_ovf), .flag_unf(flag_unf)
  );

  typedef struct {
    logic [24:0] m;
    logic [2:0]  g;
    logic [7:0]  e;
    logic        s;
    logic [31:0] lres;
    logic [2:0]  lflg;
    int          llat;
  } vec_t;
  vec_t vt[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Value-level model: {mant,G,R} as one integer plus a separate sticky bit.
  function automatic void model(input logic [24:0] m, input logic [2:0] gi, input logic [7:0] e,
                                input logic sg, output logic [31:0] res, output logic [2:0] flg,
                                output int lat);
    int          ev, nn;
    logic [31:0] ext;
    logic        st;
    logic [7:0]  ef;
`ifdef FP_ROUND_EN
    logic [24:0] mm;
    logic        up;
`endif
    ev  = (e == 8'd0) ? 1 : int'(e);
    ext = {5'b0, m, gi[2:1]};
    st  = gi[0];
    nn  = 1;
    flg = 3'b000;
    res = 32'h0;
    if (ext == 0 && !st) begin flg = 3'b100; lat = 2; return; end
    if (ev == 255) begin res = {sg, 8'hFF, 23'h0}; flg = 3'b010; lat = 2; return; end
    if (ext[26]) begin
      st  = st | ext[0];
      ext = ext >> 1;
      ev++;
      nn++;
      if (ev == 255) begin res = {sg, 8'hFF, 23'h0}; flg = 3'b010; lat = nn; return; end
    end
    while (!ext[25] && ev > 1) begin
      ext = ext << 1;
      ev--;
      nn++;
    end
    ef = ext[25] ? 8'(ev) : 8'd0;
    if (!ext[25]) flg[0] = 1'b1;
`ifdef FP_ROUND_EN
    lat = nn + 2;
    up  = ext[1] & (ext[0] | st | ext[2]);
    mm  = ext[26:2] + {24'd0, up};
    if (mm[24]) begin
      mm = mm >> 1;
      ev++;
      if (ev == 255) begin res = {sg, 8'hFF, 23'h0}; flg = 3'b010; return; end
      ef = 8'(ev);
    end else if (flg[0] && mm[23]) begin
      ef     = 8'd1;
      flg[0] = 1'b0;
    end
    res = {sg, ef, mm[22:0]};
`else
    lat = nn + 1;
    res = {sg, ef, ext[24:2]};
`endif
  endfunction

  initial begin
`ifdef FP_ROUND_EN
    vt[0]  = '{25'h0C00000, 3'b000, 8'd127, 1'b0, 32'h3FC00000, 3'b000, 3};
    vt[1]  = '{25'h1800000, 3'b000, 8'd127, 1'b0, 32'h40400000, 3'b000, 4};
    vt[2]  = '{25'h0000100, 3'b000, 8'd127, 1'b1, 32'hB8000000, 3'b000, 18};
    vt[3]  = '{25'h0000100, 3'b000, 8'd5,   1'b1, 32'h80001000, 3'b001, 7};
    vt[4]  = '{25'h0FFFFFF, 3'b100, 8'd127, 1'b0, 32'h40000000, 3'b000, 3};
    vt[5]  = '{25'h1000000, 3'b000, 8'd254, 1'b0, 32'h7F800000, 3'b010, 2};
    vt[6]  = '{25'h0000000, 3'b000, 8'd127, 1'b1, 32'h00000000, 3'b100, 2};
    vt[7]  = '{25'h0FFFFFF, 3'b100, 8'd254, 1'b0, 32'h7F800000, 3'b010, 3};
    vt[8]  = '{25'h0800000, 3'b000, 8'd0,   1'b0, 32'h00800000, 3'b000, 3};
    vt[9]  = '{25'h0800001, 3'b100, 8'd127, 1'b0, 32'h3F800002, 3'b000, 3};
    vt[10] = '{25'h07FFFFF, 3'b110, 8'd1,   1'b0, 32'h00800000, 3'b000, 3};
    vt[11] = '{25'h1000003, 3'b000, 8'd127, 1'b0, 32'h40000002, 3'b000, 4};
    vt[12] = '{25'h0000000, 3'b100, 8'd127, 1'b0, 32'h33800000, 3'b000, 27};
`else
    vt[0]  = '{25'h0C00000, 3'b000, 8'd127, 1'b0, 32'h3FC00000, 3'b000, 2};
    vt[1]  = '{25'h1800000, 3'b000, 8'd127, 1'b0, 32'h40400000, 3'b000, 3};
    vt[2]  = '{25'h0000100, 3'b000, 8'd127, 1'b1, 32'hB8000000, 3'b000, 17};
    vt[3]  = '{25'h0000100, 3'b000, 8'd5,   1'b1, 32'h80001000, 3'b001, 6};
    vt[4]  = '{25'h0FFFFFF, 3'b100, 8'd127, 1'b0, 32'h3FFFFFFF, 3'b000, 2};
    vt[5]  = '{25'h1000000, 3'b000, 8'd254, 1'b0, 32'h7F800000, 3'b010, 2};
    vt[6]  = '{25'h0000000, 3'b000, 8'd127, 1'b1, 32'h00000000, 3'b100, 2};
    vt[7]  = '{25'h0FFFFFF, 3'b100, 8'd254, 1'b0, 32'h7F7FFFFF, 3'b000, 2};
    vt[8]  = '{25'h0800000, 3'b000, 8'd0,   1'b0, 32'h00800000, 3'b000, 2};
    vt[9]  = '{25'h0800001, 3'b100, 8'd127, 1'b0, 32'h3F800001, 3'b000, 2};
    vt[10] = '{25'h07FFFFF, 3'b110, 8'd1,   1'b0, 32'h007FFFFF, 3'b001, 2};
    vt[11] = '{25'h1000003, 3'b000, 8'd127, 1'b0, 32'h40000001, 3'b000, 3};
    vt[12] = '{25'h0000000, 3'b100, 8'd127, 1'b0, 32'h33800000, 3'b000, 26};
`endif
  end

  // Output checker: every cycle a result is presented it must match the head of the queue.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL spurious_out_valid: got out_valid=1 required 0 (result %0h)", result);
      end else begin
        check("result", {32'h0, result}, {32'h0, exp_q[0][34:3]});
        check("flags", {61'h0, flag_zero, flag_ovf, flag_unf}, {61'h0, exp_q[0][2:0]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("in_ready_wait", {63'h0, in_ready}, 64'h1);
  endtask

  task automatic issue(input int i, output int mlat);
    logic [31:0] mres;
    logic [2:0]  mflg;
    model(vt[i].m, vt[i].g, vt[i].e, vt[i].s, mres, mflg, mlat);
    check($sformatf("model_res[%0d]", i), {32'h0, mres}, {32'h0, vt[i].lres});
    check($sformatf("model_flg[%0d]", i), {61'h0, mflg}, {61'h0, vt[i].lflg});
    check($sformatf("model_lat[%0d]", i), 64'(mlat), 64'(vt[i].llat));
    wait_ready();
    mant_sum = vt[i].m;
    grs      = vt[i].g;
    exp_in   = vt[i].e;
    sign_res = vt[i].s;
    in_valid = 1'b1;
    exp_q.push_back({mres, mflg});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input int i, input bit bp);
    int          mlat, k;
    logic [31:0] held;
    out_ready = ~bp;
    issue(i, mlat);
    k = 0;
    while (!out_valid && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check($sformatf("latency[%0d]", i), 64'(k + 1), 64'(mlat));
    if (bp) begin
      held = result;
      check("bp_in_ready_c1", {63'h0, in_ready}, 64'h0);
      for (int c = 2; c <= 3; c++) begin
        @(posedge clk);
        #1;
        check($sformatf("bp_valid_c%0d", c), {63'h0, out_valid}, 64'h1);
        check($sformatf("bp_stable_c%0d", c), {32'h0, result}, {32'h0, held});
        check($sformatf("bp_in_ready_c%0d", c), {63'h0, in_ready}, 64'h0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check($sformatf("post_hs_valid[%0d]", i), {63'h0, out_valid}, 64'h0);
    check($sformatf("post_hs_ready[%0d]", i), {63'h0, in_ready}, 64'h1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int mlat, seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mant_sum = '0; grs = '0; exp_in = '0; sign_res = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_result", {32'h0, result}, 64'h0);
    check("rst_flags", {61'h0, flag_zero, flag_ovf, flag_unf}, 64'h0);
    check("rst_in_ready", {63'h0, in_ready}, 64'h0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {63'h0, in_ready}, 64'h1);

    for (int i = 0; i < 13; i++) run_vec(i, 1'b0);
    run_vec(0, 1'b1);

    // Reset in the middle of a long normalization must drop the operation.
    out_ready = 1'b1;
    issue(2, mlat);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_out_valid", {63'h0, out_valid}, 64'h0);
    check("midrst_result", {32'h0, result}, 64'h0);
    check("midrst_in_ready", {63'h0, in_ready}, 64'h0);
    rst = 1'b0;
    #1;
    check("midrst_release_ready", {63'h0, in_ready}, 64'h1);
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    check("midrst_no_output", 64'(seen), 64'h0);

    run_vec(1, 1'b0);
    check("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_normalize_pack.md
Name: fp_normalize_pack

Overview:
- Back end of the FP add/sub datapath. Consumes the raw mantissa sum (with carry bit), result sign and pre-alignment exponent produced after the mantissa add/subtract stage.
- Normalizes iteratively (one bit per cycle), rounds, and packs an IEEE-754-style word.
- Valid/ready handshake on both sides; one operation in flight.

Parameters:
- EXP_W, 8, exponent field width
- MANT_W, 23, stored fraction width (hidden bit excluded)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept input
- mant_sum  in  MANT_W+2  raw sum; bit MANT_W+1 = carry, bit MANT_W = hidden position
- grs  in  3  guard/round/sticky bits from alignment, {G,R,S}
- exp_in  in  EXP_W  larger operand's biased exponent
- sign_res  in  1  result sign
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- result  out  1+EXP_W+MANT_W  packed {sign, exp, frac}
- flag_zero  out  1  result is zero
- flag_ovf  out  1  result overflowed to infinity
- flag_unf  out  1  result is denormal or flushed

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; out_valid=0, result=0, all flags=0; internal mant/exp/grs cleared. in_ready=(state==IDLE)&~rst. Reset mid-operation discards the operation with no output.
- States: IDLE, NORM, ROUND, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture mant_sum, grs, sign_res and exp_in, then go to NORM. exp_in==0 is treated as 1.
- NORM, one action per cycle, priority order:
  - (a) mant==0 and G=R=S=0: result=0 (sign forced 0), flag_zero=1, go to DONE.
  - (b) carry bit set: shift right 1. LSB->G, G->R, R|S->S. exp+1.
  - (c) hidden bit clear and exp>1: shift left 1. G->LSB, R->G, 0->R, S unchanged. exp-1.
  - (d) hidden bit clear and exp==1: denormal; stored exp=0, flag_unf=1, go to ROUND.
  - (e) otherwise go to ROUND.
  - Whenever exp reaches 2^EXP_W-1: result=±inf (frac=0), flag_ovf=1, go to DONE.
- ROUND: round-to-nearest-even, round_up = G & (R | S | LSB). mant+round_up.
  - Carry out of the hidden bit: shift right, exp+1, with overflow check as above.
  - Denormal rounding into the hidden bit sets exp=1 and clears flag_unf.
  - Pack, then go to DONE.
- DONE: out_valid=1. result and flags held stable until out_ready; on handshake go to IDLE with out_valid=0. in_ready rises the following cycle; there is no same-cycle bypass.
- Latency, input accepted at edge T, no backpressure:
  - already normalized: out_valid from T+3
  - k left shifts: T+3+k
  - carry right shift: T+4
  - zero or overflow in NORM: T+2
- Flags are mutually exclusive except flag_unf, which is cleared on zero.

Optional Feature:
- Macro: FP_ROUND_EN
- Defined: ROUND state performs RNE as above.
- Undefined: ROUND state is omitted. grs is still used as shift-in/out bits, but the final result is truncated. NORM goes straight to pack/DONE, so every non-zero, non-overflow latency above is one cycle shorter.

Test Plan:
- mant_sum=0x0C00000, exp_in=127, sign=0, grs=000 -> result 0x3FC00000, no flags, out_valid at T+3 (T+2 without FP_ROUND_EN).
- mant_sum=0x1800000, exp_in=127 -> right shift, result 0x40400000 (3.0), out_valid T+4.
- mant_sum=0x0000100, exp_in=127, sign=1 -> 15 left shifts, result 0xB8000000, out_valid T+18. Second case: exp_in=5 with the same mantissa -> flag_unf=1, exp field 0.
- mant_sum=0x0FFFFFF, exp_in=127, grs=100 -> with FP_ROUND_EN: round carry, result 0x40000000. Without it: 0x3FFFFFFF.
- mant_sum=0x1000000, exp_in=254 -> result 0x7F800000, flag_ovf=1, out_valid T+2. Second case: mant_sum=0, grs=000, sign=1 -> result 0x00000000, flag_zero=1.
- Backpressure and reset:
  - Hold out_ready=0 for 3 cycles in DONE -> result stable, in_ready=0; accepted on cycle 4, in_ready=1 the next cycle.
  - Assert rst during NORM of a 15-shift operation -> out_valid never asserts; IDLE and in_ready=1 the cycle after rst deasserts.
